// File: rtl/debug_cmd_dispatcher_pkg.sv
// Shared DebugUnit constants: command bytes, dispatcher state/mode encodings,
// and the command classifier used by the dispatcher's DECODE state.
package debug_cmd_dispatcher_pkg;

  localparam int UART_BITS = 8;

  localparam logic [UART_BITS-1:0] CMD_LOAD = 8'h4C;
  localparam logic [UART_BITS-1:0] CMD_RUN  = 8'h52;
  localparam logic [UART_BITS-1:0] CMD_STEP = 8'h53;
  localparam logic [UART_BITS-1:0] CMD_EXIT = 8'h45;
  localparam logic [UART_BITS-1:0] NAK_BYTE = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_ACK  = 3'd5,
    ST_STEP_IDLE = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_STEP = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    OP_LOAD,
    OP_RUN,
    OP_STEP,
    OP_EXIT,
    OP_NAK
  } op_t;

  // Load/run are refused while stepping; exit is only meaningful while stepping.
  function automatic op_t decode_cmd(input logic [UART_BITS-1:0] b, input logic step_mode);
    op_t op;
    op = OP_NAK;
    if (b == CMD_LOAD && !step_mode)     op = OP_LOAD;
    else if (b == CMD_RUN && !step_mode) op = OP_RUN;
    else if (b == CMD_STEP)              op = OP_STEP;
    else if (b == CMD_EXIT && step_mode) op = OP_EXIT;
    return op;
  endfunction

endpackage

// File: rtl/debug_cmd_dispatcher.sv
// DebugUnit command sequencer: decodes host bytes, runs one sub-FSM at a time.
// Define DBG_DISPATCH_ACK_EN to echo an ack/NAK byte per command over the UART.
module debug_cmd_dispatcher
  import debug_cmd_dispatcher_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [UART_BITS-1:0] i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_load_done,
  input  logic                 i_run_done,
  input  logic                 i_step_done,
  input  logic                 i_tx_done,
  output logic                 o_load_start,
  output logic                 o_run_start,
  output logic                 o_step_start,
  output logic                 o_tx_start,
  output logic [UART_BITS-1:0] o_tx_data,
  output logic                 o_busy,
  output logic                 o_step_mode,
  output logic                 o_drop
);

  state_t               state, state_nxt;
  mode_t                mode, mode_nxt;
  logic                 step_mode, step_mode_nxt;
  logic [UART_BITS-1:0] cmd;
  logic                 drop_q;
  logic                 idle_like;
  logic                 sel_done;
  op_t                  op;

  assign idle_like = (state == ST_IDLE) || (state == ST_STEP_IDLE);
  assign op        = decode_cmd(cmd, step_mode);

  always_comb begin
    sel_done = 1'b0;
    unique case (mode)
      MODE_LOAD: sel_done = i_load_done;
      MODE_RUN:  sel_done = i_run_done;
      MODE_STEP: sel_done = i_step_done;
      default:   sel_done = 1'b0;
    endcase
  end

`ifdef DBG_DISPATCH_ACK_EN
  logic                 nak, nak_nxt;
  logic [UART_BITS-1:0] tx_data;

  always_comb begin
    state_nxt     = state;
    mode_nxt      = mode;
    step_mode_nxt = step_mode;
    nak_nxt       = nak;
    unique case (state)
      ST_IDLE, ST_STEP_IDLE:
        if (i_rx_done) state_nxt = ST_DECODE;
      ST_DECODE: begin
        nak_nxt = 1'b0;
        unique case (op)
          OP_LOAD: begin mode_nxt = MODE_LOAD; state_nxt = ST_START; end
          OP_RUN:  begin mode_nxt = MODE_RUN;  state_nxt = ST_START; end
          OP_STEP: begin
            mode_nxt      = MODE_STEP;
            step_mode_nxt = 1'b1;
            state_nxt     = ST_START;
          end
          OP_EXIT: begin step_mode_nxt = 1'b0; state_nxt = ST_ACK; end
          default: begin nak_nxt = 1'b1; state_nxt = ST_ACK; end
        endcase
      end
      ST_START:     state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (sel_done) state_nxt = ST_ACK;
      ST_ACK:       state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK:
        if (i_tx_done) state_nxt = step_mode ? ST_STEP_IDLE : ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // ACK lasts a single cycle, so loading on entry keeps the byte stable until tx_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nak     <= 1'b0;
      tx_data <= '0;
    end else begin
      nak <= nak_nxt;
      if (state_nxt == ST_ACK && state != ST_ACK)
        tx_data <= nak_nxt ? NAK_BYTE : cmd;
    end
  end

  assign o_tx_start = (state == ST_ACK);
  assign o_tx_data  = tx_data;
`else
  logic tx_done_unused;
  assign tx_done_unused = i_tx_done;

  always_comb begin
    state_nxt     = state;
    mode_nxt      = mode;
    step_mode_nxt = step_mode;
    unique case (state)
      ST_IDLE, ST_STEP_IDLE:
        if (i_rx_done) state_nxt = ST_DECODE;
      ST_DECODE: begin
        unique case (op)
          OP_LOAD: begin mode_nxt = MODE_LOAD; state_nxt = ST_START; end
          OP_RUN:  begin mode_nxt = MODE_RUN;  state_nxt = ST_START; end
          OP_STEP: begin
            mode_nxt      = MODE_STEP;
            step_mode_nxt = 1'b1;
            state_nxt     = ST_START;
          end
          OP_EXIT: begin step_mode_nxt = 1'b0; state_nxt = ST_IDLE; end
          default: state_nxt = step_mode ? ST_STEP_IDLE : ST_IDLE;
        endcase
      end
      ST_START: state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE:
        if (sel_done) state_nxt = step_mode ? ST_STEP_IDLE : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign o_tx_start = 1'b0;
  assign o_tx_data  = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode      <= MODE_LOAD;
      step_mode <= 1'b0;
      cmd       <= '0;
      drop_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode      <= mode_nxt;
      step_mode <= step_mode_nxt;
      if (idle_like && i_rx_done) cmd <= i_rx_data;
      // Registered so o_drop stays Moore; it trails the discarded strobe by one edge.
      drop_q    <= i_rx_done && !idle_like;
    end
  end

  assign o_load_start = (state == ST_START) && (mode == MODE_LOAD);
  assign o_run_start  = (state == ST_START) && (mode == MODE_RUN);
  assign o_step_start = (state == ST_START) && (mode == MODE_STEP);
  assign o_busy       = !idle_like;
  assign o_step_mode  = step_mode;
  assign o_drop       = drop_q;

endmodule

// File: tb/tb_debug_cmd_dispatcher.sv
// Directed + randomized command sequences checked against a transaction-level host model.
module tb_debug_cmd_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done, load_done, run_done, step_done, tx_done;
  logic       load_start, run_start, step_start, tx_start, busy, step_mode, drop;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;
  bit model_sm = 1'b0;

`ifdef DBG_DISPATCH_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  debug_cmd_dispatcher dut (
    .clk(clk), .rst(rst),
    .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_load_done(load_done), .i_run_done(run_done), .i_step_done(step_done),
    .i_tx_done(tx_done),
    .o_load_start(load_start), .o_run_start(run_start), .o_step_start(step_start),
    .o_tx_start(tx_start), .o_tx_data(tx_data),
    .o_busy(busy), .o_step_mode(step_mode), .o_drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_done(input int kind, input logic v);
    if (kind == 0) load_done = v;
    if (kind == 1) run_done  = v;
    if (kind == 2) step_done = v;
  endtask

  // One full host transaction. kind: 0 load, 1 run, 2 step, 3 no sub-FSM.
  task automatic do_cmd(input logic [7:0] b, input int done_dly, input int tx_dly,
                        input bit intrude, input bit early, input bit late_rx);
    int kind;
    bit nsm, is_exit;
    logic [7:0] ack;
    logic [2:0] starts;
    kind = 3;
    nsm = model_sm;
    is_exit = (b == 8'h45) && model_sm;
    if (b == 8'h4C && !model_sm)      kind = 0;
    else if (b == 8'h52 && !model_sm) kind = 1;
    else if (b == 8'h53) begin kind = 2; nsm = 1'b1; end
    if (is_exit) nsm = 1'b0;
    ack = (kind == 3 && !is_exit) ? 8'h3F : b;

    rx_data = b; rx_done = 1'b1;
    tick();
    rx_done = 1'b0; rx_data = 8'($urandom);
    chk("decode_busy", busy, 1);
    chk("decode_nostart", {step_start, run_start, load_start}, 0);

    if (kind < 3) begin
      tick();
      starts = {step_start, run_start, load_start};
      chk("start_pulse", starts, 3'b001 << kind);
      chk("start_stepmode", step_mode, nsm);
      if (early) set_done(kind, 1'b1);
      tick();
      set_done(kind, 1'b0);
      chk("wait_nostart", {step_start, run_start, load_start}, 0);
      chk("wait_busy", busy, 1);
      chk("wait_notx", tx_start, 0);
      for (int i = 0; i < done_dly; i++) begin
        if (intrude && i == 0) begin
          rx_done = 1'b1;
          set_done((kind + 1) % 3, 1'b1);
          tick();
          rx_done = 1'b0;
          set_done((kind + 1) % 3, 1'b0);
          chk("intrude_drop", drop, 1);
        end else begin
          tick();
          chk("wait_nodrop", drop, 0);
        end
        chk("wait_still_busy", busy, 1);
        chk("wait_still_notx", tx_start, 0);
      end
      set_done(kind, 1'b1);
      if (!ACK && late_rx) rx_done = 1'b1;
      tick();
      set_done(kind, 1'b0);
      rx_done = 1'b0;
    end else begin
      tick();
      chk("nocmd_nostart", {step_start, run_start, load_start}, 0);
    end

    if (ACK) begin
      chk("ack_txstart", tx_start, 1);
      chk("ack_txdata", tx_data, ack);
      chk("ack_busy", busy, 1);
      for (int i = 0; i < tx_dly; i++) begin
        tick();
        chk("waitack_notx", tx_start, 0);
        chk("waitack_hold", tx_data, ack);
        chk("waitack_busy", busy, 1);
      end
      tx_done = 1'b1;
      rx_done = late_rx;
      tick();
      tx_done = 1'b0;
      rx_done = 1'b0;
      chk("end_busy", busy, 0);
      chk("end_drop", drop, late_rx);
    end else begin
      chk("end_busy", busy, 0);
      chk("end_notx", {tx_start, tx_data}, 0);
      chk("end_drop", drop, late_rx && kind < 3);
    end
    chk("end_stepmode", step_mode, nsm);
    tick();
    chk("idle_stays", busy, 0);
    chk("idle_nodrop", drop, 0);
    model_sm = nsm;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] tbl [4];
    tbl[0] = 8'h4C; tbl[1] = 8'h52; tbl[2] = 8'h53; tbl[3] = 8'h45;
    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0;
    load_done = 1'b0; run_done = 1'b0; step_done = 1'b0; tx_done = 1'b0;
    tick(); tick();
    chk("rst_outs", {load_start, run_start, step_start, tx_start, busy, step_mode, drop}, 0);
    chk("rst_txdata", tx_data, 0);
    rst = 1'b0;
    tick();

    do_cmd(8'h4C, 4, 3, 0, 0, 0);
    do_cmd(8'h00, 0, 2, 0, 0, 0);
    do_cmd(8'h53, 2, 1, 0, 0, 0);
    do_cmd(8'h53, 0, 0, 0, 1, 0);
    do_cmd(8'h52, 0, 1, 0, 0, 0);
    do_cmd(8'h4C, 0, 0, 0, 0, 0);
    do_cmd(8'h45, 0, 2, 0, 0, 0);
    do_cmd(8'h45, 0, 1, 0, 0, 0);
    do_cmd(8'h52, 3, 1, 1, 1, 1);

    // Abort a step command mid-flight.
    rx_data = 8'h53; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick(); tick();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_stepmode", step_mode, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", {load_start, run_start, step_start, tx_start, busy, step_mode, drop}, 0);
    chk("async_rst_txdata", tx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    model_sm = 1'b0;
    tick();
    do_cmd(8'h4C, 4, 3, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 4) b = 8'($urandom);
      else b = tbl[$urandom_range(0, 3)];
      do_cmd(b, $urandom_range(0, 5), $urandom_range(0, 4),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_cmd_dispatcher.md
# debug_cmd_dispatcher

Top-level command sequencer of the DebugUnit. Receives command bytes from the UART receiver and decodes them into load-program, run and single-step operations. Starts exactly one sub-FSM (program loader, run FSM, step FSM) at a time and waits for its completion. Optionally echoes an acknowledge byte to the UART transmitter, giving the host a strict one-command-at-a-time protocol.

## Interface
- UART_BITS, 8, width of rx/tx bytes
- CMD_LOAD, 8'h4C ('L'), load program
- CMD_RUN, 8'h52 ('R'), run to halt
- CMD_STEP, 8'h53 ('S'), enter step mode / execute one step
- CMD_EXIT, 8'h45 ('E'), leave step mode
- NAK_BYTE, 8'h3F, reply to an unknown command

Ports:
- clk  in  1  single clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- i_rx_data  in  UART_BITS  received byte, valid with i_rx_done
- i_rx_done  in  1  one-cycle strobe, new byte available
- i_load_done / i_run_done / i_step_done  in  1 each  one-cycle completion strobes from the sub-FSMs
- i_tx_done  in  1  transmitter finished the current byte
- o_load_start / o_run_start / o_step_start  out  1 each  one-cycle start pulses
- o_tx_start  out  1  one-cycle pulse, send o_tx_data
- o_tx_data  out  UART_BITS  ack byte; held stable until i_tx_done
- o_busy  out  1  high in every state except IDLE and STEP_IDLE
- o_step_mode  out  1  high while in step mode
- o_drop  out  1  one-cycle pulse when an rx byte is discarded

## Operation
- States: IDLE, DECODE, START, WAIT_DONE, ACK, WAIT_ACK, STEP_IDLE.
- IDLE: on i_rx_done, latch i_rx_data into cmd register → DECODE.
- DECODE (1 cycle), by latched byte:
  - L → START, mode LOAD.
  - R → START, mode RUN.
  - S → START, mode STEP; set step_mode.
  - E is valid only when step_mode=1; then clear step_mode → ACK with the echoed byte.
  - Anything else → ACK with NAK_BYTE.
- START (1 cycle): pulse the start output selected by mode → WAIT_DONE.
- WAIT_DONE: wait for the done strobe of the selected mode. Done strobes of non-selected modes are ignored. On done → ACK.
- ACK: o_tx_data = latched cmd byte (or NAK_BYTE), pulse o_tx_start → WAIT_ACK.
- WAIT_ACK: on i_tx_done → STEP_IDLE if step_mode, else IDLE.
- STEP_IDLE: on i_rx_done, latch byte → DECODE.
  - S executes one more step.
  - E exits step mode.
  - L and R are NAKed; step mode persists.
- A byte received in any state other than IDLE or STEP_IDLE is discarded with o_drop, with no state change.
- All outputs are Moore, driven from registered state; o_tx_data is a register.

## Timing
- Reset: state=IDLE, step_mode=0, cmd=0, o_tx_data=0; all pulses 0, o_busy=0, o_step_mode=0.
- Reset mid-operation aborts immediately; sub-FSMs are reset by the same rst.
- Latency: i_rx_done at cycle N → DECODE at N+1 → start pulse during N+2.
- Done strobe at cycle M → o_tx_start during M+1.
- A done strobe coincident with the start pulse is ignored; it is accepted from the first WAIT_DONE cycle.
- An i_rx_done coincident with the WAIT_ACK→IDLE transition is dropped (o_drop=1).
- Minimum command-to-command spacing is therefore bounded by i_tx_done.

## Configuration
- DBG_DISPATCH_ACK_EN defined: behaviour as above.
- Not defined:
  - ACK and WAIT_ACK are removed; o_tx_start is tied 0 and o_tx_data is tied 0.
  - WAIT_DONE goes directly to STEP_IDLE/IDLE.
  - DECODE goes directly to IDLE/STEP_IDLE for NAK cases and for E.

## Structure
- Shared debug package/header (constants.vh) holds:
  - the CMD_* and NAK_BYTE values;
  - the state encodings (3 bits);
  - the mode encoding (LOAD=0, RUN=1, STEP=2).
- No sub-module; single FSM plus cmd/mode/step_mode registers.

## Test plan
- Reset, then L byte; i_load_done 5 cycles after o_load_start → o_load_start is 1 cycle, 2 cycles after i_rx_done; o_tx_data=8'h4C with o_tx_start; after i_tx_done, IDLE and o_busy=0.
- Byte 8'h00 → no start pulse; o_tx_data=8'h3F; returns to IDLE.
- S, done, S, done, E → two o_step_start pulses; o_step_mode=1 until the E ack completes; echoes 53,53,45.
- In step mode, R → NAK 8'h3F; o_step_mode stays 1; no o_run_start.
- R issued, then a second byte during WAIT_DONE, plus a spurious i_load_done → o_drop pulse, no state change, still waiting for i_run_done.
- rst asserted during WAIT_DONE → all outputs 0 asynchronously; after release, an L command behaves as in the first scenario.
